// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder for the fetch stage.
// Word-organised synchronous RAM at BASE_ADDR with a one-cycle read latency,
// byte-enable writes, a full-word side preload port, a sticky out-of-range
// error capture and saturating read/write access counters.
module inst_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1c000000,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] FILL_WORD = 32'h03400000,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_idx,
  input  logic [31:0]       ld_data,
  output logic              addr_err,
  output logic [31:0]       err_addr,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int               DEPTH      = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Storage; deliberately has no reset so boot contents survive a CPU reset.
  logic [31:0]       r_mem [DEPTH];

  logic [31:0]       r_rdata;
  logic              r_addr_err;
  logic [31:0]       r_err_addr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;

  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_is_write;
  logic              w_cpu_wr;

  // Address decode and CPU write qualification (preload collision drops the CPU write).
  always_comb begin
    w_in_range = (inst_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    w_idx      = inst_sram_addr[ADDR_W+1:2];
    w_is_write = (inst_sram_we != 4'h0);
    if (inst_sram_en && w_is_write && w_in_range && !(ld_en && (ld_idx == w_idx))) begin
      w_cpu_wr = 1'b1;
    end else begin
      w_cpu_wr = 1'b0;
    end
  end

  // RAM update: CPU byte writes and full-word preload; nothing is written while reset is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // contents are intentionally retained across reset
    end else begin
      if (w_cpu_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (inst_sram_we[i]) begin
            r_mem[w_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
          end
        end
      end
      if (ld_en) begin
        r_mem[ld_idx] <= ld_data;
      end
    end
  end

  // Read data, error capture and saturating counters; rdata holds while en is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata    <= 32'h0000_0000;
      r_addr_err <= 1'b0;
      r_err_addr <= 32'h0000_0000;
      r_rd_cnt   <= {CNT_W{1'b0}};
      r_wr_cnt   <= {CNT_W{1'b0}};
    end else if (inst_sram_en) begin
      if (w_in_range) begin
        // read-before-write: a write returns the word as it was before this edge
        r_rdata <= r_mem[w_idx];
        if (w_is_write) begin
          if (r_wr_cnt != CNT_MAX) begin
            r_wr_cnt <= r_wr_cnt + CNT_ONE;
          end
        end else begin
          if (r_rd_cnt != CNT_MAX) begin
            r_rd_cnt <= r_rd_cnt + CNT_ONE;
          end
        end
      end else begin
        r_rdata    <= FILL_WORD;
        r_addr_err <= 1'b1;
        // only the first offending address is kept for debug
        if (!r_addr_err) begin
          r_err_addr <= inst_sram_addr;
        end
      end
    end
  end

  assign inst_sram_rdata = r_rdata;
  assign addr_err        = r_addr_err;
  assign err_addr        = r_err_addr;
  assign rd_cnt          = r_rd_cnt;
  assign wr_cnt          = r_wr_cnt;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: a byte-level memory model
// predicts outputs every cycle, plus directed literal expectations.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE = 32'h1c000000;
  localparam logic [31:0] SPAN = 32'h0000_4000;   // 4096 words * 4 bytes
  localparam logic [31:0] FILL = 32'h03400000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_idx = 12'h0;
  logic [31:0] ld_data = 32'h0;

  logic [31:0] rdata, err_addr, rd_cnt, wr_cnt;
  logic        addr_err;
  logic [31:0] s_rdata, s_err_addr;
  logic        s_addr_err;
  logic [1:0]  s_rd_cnt, s_wr_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_sram_responder dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(en), .inst_sram_we(we), .inst_sram_addr(addr),
    .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .addr_err(addr_err), .err_addr(err_addr),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // narrow-counter copy used to observe saturation
  inst_sram_responder #(.CNT_W(2)) u_sat (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(en), .inst_sram_we(we), .inst_sram_addr(addr),
    .inst_sram_wdata(wdata), .inst_sram_rdata(s_rdata),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .addr_err(s_addr_err), .err_addr(s_err_addr),
    .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_byte [int unsigned];
  logic [31:0] e_rdata = 32'h0;
  bit          e_known = 1'b1;
  bit          e_err = 1'b0;
  logic [31:0] e_err_addr = 32'h0;
  int          m_rd = 0;
  int          m_wr = 0;
  bit          done = 1'b0;

  always @(negedge resetn) begin
    e_rdata = 32'h0; e_known = 1'b1; e_err = 1'b0; e_err_addr = 32'h0;
    m_rd = 0; m_wr = 0;
  end

  always @(posedge clk) begin
    int unsigned wb;
    if (resetn) begin
      if (en) begin
        if (addr >= BASE && (addr - BASE) < SPAN) begin
          wb = (addr - BASE) & 32'hffff_fffc;
          e_known = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (m_byte.exists(wb + b)) e_rdata[8*b +: 8] = m_byte[wb + b];
            else e_known = 1'b0;
          end
          if (we == 4'h0) m_rd++;
          else begin
            m_wr++;
            if (!(ld_en && (int'(ld_idx) * 4 == wb)))
              for (int b = 0; b < 4; b++)
                if (we[b]) m_byte[wb + b] = wdata[8*b +: 8];
          end
        end else begin
          e_rdata = FILL; e_known = 1'b1;
          if (!e_err) e_err_addr = addr;
          e_err = 1'b1;
        end
      end
      if (ld_en)
        for (int b = 0; b < 4; b++) m_byte[int'(ld_idx) * 4 + b] = ld_data[8*b +: 8];
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (!done) begin
      if (e_known) chk("rdata", rdata, e_rdata);
      chk("addr_err", {31'h0, addr_err}, {31'h0, e_err});
      chk("err_addr", err_addr, e_err_addr);
      chk("rd_cnt", rd_cnt, m_rd);
      chk("wr_cnt", wr_cnt, m_wr);
      chk("sat_rd_cnt", {30'h0, s_rd_cnt}, (m_rd > 3) ? 3 : m_rd);
      chk("sat_wr_cnt", {30'h0, s_wr_cnt}, (m_wr > 3) ? 3 : m_wr);
    end
  end

  // one cycle: apply inputs now, let an edge pass, return at the following negedge
  task automatic step(input bit e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input bit l, input logic [11:0] li,
                      input logic [31:0] ld);
    en = e; we = w; addr = a; wdata = d; ld_en = l; ld_idx = li; ld_data = ld;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 4'h0, a, 32'h0, 1'b0, 12'h0, 32'h0);
  endtask

  initial begin
    idle(); idle();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_cnt", rd_cnt | wr_cnt, 32'h0);
    chk("reset_err", {31'h0, addr_err}, 32'h0);

    resetn = 1'b1;
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 12'd0, 32'h12345678);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 12'd1, 32'h9abcdef0);
    chk("preload_no_rdata", rdata, 32'h0);

    rd(32'h1c000000);
    chk("read0", rdata, 32'h12345678);
    rd(32'h1c000004);
    chk("read1", rdata, 32'h9abcdef0);
    chk("rd_cnt2", rd_cnt, 32'd2);

    step(1'b1, 4'b0101, 32'h1c000000, 32'hAABBCCDD, 1'b0, 12'h0, 32'h0);
    chk("wr_old_word", rdata, 32'h12345678);
    chk("wr_cnt1", wr_cnt, 32'd1);
    rd(32'h1c000002);   // low address bits ignored
    chk("byte_merge", rdata, 32'h12BB56DD);

    rd(32'h1c000004);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("idle_hold", rdata, 32'h9abcdef0);
    end

    rd(32'h00000100);
    chk("oor_fill0", rdata, FILL);
    chk("oor_flag", {31'h0, addr_err}, 32'h1);
    rd(32'h1c0ffff0);
    chk("oor_fill1", rdata, FILL);
    chk("err_first", err_addr, 32'h00000100);
    chk("oor_rd_cnt", rd_cnt, 32'd4);

    step(1'b1, 4'hf, 32'h1c000008, 32'h22222222, 1'b1, 12'd2, 32'h11111111);
    chk("collide_wr_cnt", wr_cnt, 32'd2);
    rd(32'h1c000008);
    chk("preload_wins", rdata, 32'h11111111);

    step(1'b1, 4'h0, 32'h1c000000, 32'h0, 1'b1, 12'd0, 32'hCAFEF00D);
    chk("ld_rd_old", rdata, 32'h12BB56DD);
    rd(32'h1c000000);
    chk("ld_rd_new", rdata, 32'hCAFEF00D);

    step(1'b1, 4'hf, 32'h20000000, 32'hdeadbeef, 1'b0, 12'h0, 32'h0);
    chk("oor_wr_fill", rdata, FILL);
    chk("oor_wr_cnt", wr_cnt, 32'd2);
    chk("err_sticky", err_addr, 32'h00000100);

    step(1'b1, 4'hf, 32'h1c00000c, 32'h01020304, 1'b0, 12'h0, 32'h0);
    step(1'b1, 4'hf, 32'h1c00000c, 32'h05060708, 1'b0, 12'h0, 32'h0);
    rd(32'h1c00000c);
    chk("last_write", rdata, 32'h05060708);
    chk("sat_rd", {30'h0, s_rd_cnt}, 32'd3);
    chk("sat_wr", {30'h0, s_wr_cnt}, 32'd3);
    chk("wide_wr", wr_cnt, 32'd4);

    // asynchronous reset between edges
    #1 resetn = 1'b0;
    #1;
    chk("async_rdata", rdata, 32'h0);
    chk("async_cnt", rd_cnt | wr_cnt, 32'h0);
    chk("async_err", {31'h0, addr_err}, 32'h0);
    chk("async_err_addr", err_addr, 32'h0);
    @(negedge clk);
    // write attempted while reset is held must be ignored
    step(1'b1, 4'hf, 32'h1c000004, 32'h00000000, 1'b0, 12'h0, 32'h0);
    resetn = 1'b1;
    rd(32'h1c000004);
    chk("mem_kept", rdata, 32'h9abcdef0);
    chk("post_rst_rd_cnt", rd_cnt, 32'd1);
    idle();

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Responder end of the instruction SRAM interface driven by the fetch stage: en/we/addr/wdata in, rdata out, fixed one-cycle read latency.
- Word-organised synchronous RAM mapped at BASE_ADDR, with byte-enable writes.
- Out-of-range accesses return a NOP fill word and raise a sticky error flag.
- Has a side preload port for bench and boot loading, plus access counters for performance and debug.

Parameters:
- BASE_ADDR, 32'h1c000000, byte address of word 0; must be aligned to 4*DEPTH.
- ADDR_W, 12, word-index width; DEPTH = 2**ADDR_W words.
- FILL_WORD, 32'h03400000, value returned for out-of-range reads (LoongArch NOP, andi r0,r0,0).
- CNT_W, 32, width of the access counters.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_sram_en  in  1  access request this cycle.
- inst_sram_we  in  4  byte write enables; 4'h0 means read.
- inst_sram_addr  in  32  byte address; bits[1:0] ignored.
- inst_sram_wdata  in  32  write data; byte i = bits[8i+7:8i].
- inst_sram_rdata  out  32  read data, valid the cycle after an accepted read.
- ld_en  in  1  preload write strobe (full word).
- ld_idx  in  ADDR_W  preload word index.
- ld_data  in  32  preload word.
- addr_err  out  1  sticky out-of-range flag.
- err_addr  out  32  byte address of the first out-of-range access.
- rd_cnt  out  CNT_W  accepted in-range reads.
- wr_cnt  out  CNT_W  accepted in-range writes (CPU port only).

Behaviour:
- Reset (resetn=0, asynchronous):
  - rdata=0, addr_err=0, err_addr=0, rd_cnt=0, wr_cnt=0.
  - RAM contents are not reset.
  - A deassertion mid-stream takes effect at the next clock edge; no access is taken in the reset cycle.
- Decode: in_range = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]); idx = addr[ADDR_W+1:2].
- Read (en=1, we=0, in_range):
  - rdata <= mem[idx] at the rising edge.
  - Visible one cycle later; a back-to-back read every cycle is sustained.
  - rd_cnt+1.
- Write (en=1, we!=0, in_range):
  - Each byte i with we[i]=1 is updated from wdata.
  - rdata <= old mem[idx] (read-before-write).
  - wr_cnt+1.
- Idle (en=0): rdata holds its last value. The fetch stage relies on this while stalled.
- Out of range (en=1, !in_range):
  - No RAM write.
  - rdata <= FILL_WORD.
  - addr_err <= 1.
  - err_addr latched only if addr_err was 0 beforehand (first error kept).
  - Counters unchanged.
- Preload:
  - ld_en=1 writes mem[ld_idx] <= ld_data.
  - It is independent of en and does not affect rdata or the counters.
- Simultaneous preload and CPU write to the same idx: preload wins for all bytes; the CPU write is dropped and wr_cnt still increments.
- Simultaneous preload and CPU read of the same idx: rdata returns the old word.
- Counters saturate at all-ones; they do not wrap.
- addr_err clears only on reset.

Test Plan:
- Preload mem[0]=32'h12345678, mem[1]=32'h9abcdef0; read 0x1c000000 then 0x1c000004 on consecutive cycles -> rdata 12345678 then 9abcdef0 one cycle after each request; rd_cnt=2.
- Byte write we=4'b0101, wdata=32'hAABBCCDD to 0x1c000000 holding 12345678 -> rdata that cycle is 12345678; a later read gives 12BB56DD; wr_cnt=1.
- Read 0x1c000004, then en=0 for 3 cycles -> rdata stays 9abcdef0 throughout.
- Read 0x00000100, then 0x1c0ffff0 (ADDR_W=12) -> rdata 03400000 both times; addr_err=1; err_addr=00000100; rd_cnt unchanged.
- Same cycle: ld_en to idx 2 with 11111111 and CPU write to 0x1c000008 with we=4'hf, wdata=22222222 -> a later read gives 11111111; wr_cnt increments.
- Assert resetn=0 between clock edges after traffic -> rdata, counters, addr_err and err_addr go to 0 immediately; preloaded mem[1] still reads 9abcdef0 after release.
